zcu102_base: RTL and testbench
==============================

// Module: zcu102_base
// PURPOSE
//  AXI4-Lite slave peripheral block for the ZCU102 base platform. Provides PS access to
//  LEDs, switches, push-buttons, a UART and an aux reset. Raises one level interrupt to the PS.
// PARAMETERS
//  P_ADDR_WIDTH  8     AXI address width (byte address; word registers, addr[1:0] ignored)
//  P_DATA_WIDTH  32    AXI data width (only 32 supported)
//  P_NUM_LED     8     LED outputs
//  P_NUM_SWITCH  8     switch inputs
//  P_NUM_BUTTON  5     button inputs
//  P_BAUD_DIV    868   ACLK cycles per UART bit (100 MHz / 115200)
// PORTS
//  ACLK        in   1   clock; all logic on rising edge
//  ARESET      in   1   synchronous, active-high reset
//  s_awvalid/s_awready in/out 1; s_awaddr in P_ADDR_WIDTH; s_awprot in 3 (ignored)
//  s_wvalid/s_wready in/out 1; s_wdata in P_DATA_WIDTH; s_wstrb in P_DATA_WIDTH/8
//  s_bvalid/s_bready out/in 1; s_bresp out 2
//  s_arvalid/s_arready in/out 1; s_araddr in P_ADDR_WIDTH; s_arprot in 3 (ignored)
//  s_rvalid/s_rready out/in 1; s_rdata out P_DATA_WIDTH; s_rresp out 2
//  irq out 1 level interrupt; leds out P_NUM_LED; switches in P_NUM_SWITCH; buttons in P_NUM_BUTTON
//  uart_rxd in 1; uart_txd out 1 (idle high); aux_resetn out 1 active-low reset to fabric
// BEHAVIOUR
//  Reset: awready=wready=arready=1, bvalid=rvalid=0, bresp=rresp=0, rdata=0, irq=0, leds=0,
//   uart_txd=1, aux_resetn=0 while ARESET high, 1 after; all registers 0.
//  Write: AW and W captured independently; awready drops once an address is held, wready once
//   data is held. When both held and bvalid=0: apply write (honour wstrb), next cycle bvalid=1,
//   bresp=2'b00. bvalid holds until bready; then holders clear, awready/wready return to 1.
//  Read: arready=1 while rvalid=0; on arvalid&arready, next cycle rvalid=1, rdata, rresp=00;
//   hold until rready. Unmapped reads return 0, unmapped writes ignored; rresp/bresp always OKAY.
//  Register map (word offset):
//   0x00 LED RW [P_NUM_LED-1:0] -> leds
//   0x04 SWITCH RO synchronised switches;  0x08 BUTTON RO synchronised buttons
//   0x0C IRQ_STAT W1C: [4:0] button rising edge, [8] any switch change, [9] uart rx byte, [10] tx done
//   0x10 IRQ_EN RW same bit layout;  irq = |(IRQ_STAT & IRQ_EN), registered (1 cycle)
//   0x14 UART_TX WO [7:0]: write starts frame if tx idle, else dropped
//   0x18 UART_RX RO [7:0] last byte; read clears rx_valid
//   0x1C UART_STAT RO [0] tx_busy, [1] rx_valid, [2] rx_overrun (cleared by reading 0x18)
//   0x20 CTRL RW [0] aux reset request: aux_resetn = ~(ARESET | CTRL[0])
//   0xFC SCRATCH RW 32-bit
//  Inputs: switches, buttons, uart_rxd pass 2-flop synchronisers before use.
//  Edge event and W1C on same bit same cycle: set wins.
//  UART 8N1, LSB first, bit period P_BAUD_DIV; rx samples mid-bit, false start (low <half bit) rejected;
//   stop bit low -> byte discarded. New byte while rx_valid=1 sets rx_overrun and overwrites.
//  ARESET mid-transaction aborts it: handshakes return to reset state, UART frame abandoned, txd=1.
// STRUCTURE
//  Package zcu102_base_pkg: register offset localparams, IRQ bit indices, OKAY=2'b00.
//  Sub-module zcu102_base_uart (tx+rx, baud counter); top holds AXI FSM, regs, sync, irq.
// TESTING
//  Reset 5 cycles -> awready=arready=1, leds=0, txd=1, aux_resetn=0 then 1 after release.
//  AW 0xFF alone, W 0xDEADBEEF 3 cycles later -> bvalid once both held; read 0xFC = 0xDEADBEEF.
//  Write 0x00=0xA5 wstrb=4'b0001 -> leds=8'hA5; read 0x00 -> 0x000000A5; write 0x40 -> no change.
//  IRQ_EN=0x1F, pulse buttons[2] -> irq=1, IRQ_STAT=0x4; write 0x4 to 0x0C -> irq=0.
//  Write 0x14=0x55 -> txd frame 0,10101010,1 at P_BAUD_DIV per bit; loop txd->rxd -> 0x18=0x55.
//  Hold bready=0 10 cycles -> bvalid stays 1, awready stays 0; CTRL[0]=1 -> aux_resetn=0.

Source files
------------

// File: rtl/zcu102_base_pkg.sv
// Shared definitions for the ZCU102 base peripheral block.
//  - register byte offsets (word aligned, addr[1:0] ignored by the decoder)
//  - bit positions inside IRQ_STAT / IRQ_EN
//  - AXI response code and the FSM state encodings
//  - apply_strb(): byte-lane merge of a write into an existing register value
package zcu102_base_pkg;

    localparam logic [7:0] ADDR_LED       = 8'h00;
    localparam logic [7:0] ADDR_SWITCH    = 8'h04;
    localparam logic [7:0] ADDR_BUTTON    = 8'h08;
    localparam logic [7:0] ADDR_IRQ_STAT  = 8'h0C;
    localparam logic [7:0] ADDR_IRQ_EN    = 8'h10;
    localparam logic [7:0] ADDR_UART_TX   = 8'h14;
    localparam logic [7:0] ADDR_UART_RX   = 8'h18;
    localparam logic [7:0] ADDR_UART_STAT = 8'h1C;
    localparam logic [7:0] ADDR_CTRL      = 8'h20;
    localparam logic [7:0] ADDR_SCRATCH   = 8'hFC;

    // IRQ_STAT / IRQ_EN layout: [4:0] button rising edges, then these
    localparam int IRQ_SW = 8;
    localparam int IRQ_RX = 9;
    localparam int IRQ_TX = 10;
    localparam int IRQ_W  = 11;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic       {WR_COLLECT, WR_RESP} wr_state_e;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    // Bytes whose strobe is set take the new value, the rest keep the old one.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/zcu102_base_uart.sv
// 8N1 UART transmitter + receiver, LSB first, one bit every P_BAUD_DIV clocks.
// Ports:
//  ACLK, ARESET          clock, synchronous active-high reset
//  tx_start, tx_data     request a frame; ignored while a frame is in flight
//  txd, tx_busy, tx_done serial out (idle high), busy flag, 1-cycle pulse at end of stop bit
//  rxd                   serial in, already synchronised by the caller
//  rx_clear              consumer has read rx_data; clears rx_valid and rx_overrun
//  rx_data, rx_valid     last good byte and its flag
//  rx_overrun            a byte arrived while rx_valid was still set
//  rx_byte               1-cycle pulse per accepted byte
module zcu102_base_uart
    import zcu102_base_pkg::*;
#(
    parameter int P_BAUD_DIV = 868
)
(
    input  logic       ACLK,
    input  logic       ARESET,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_done,
    input  logic       rxd,
    input  logic       rx_clear,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_overrun,
    output logic       rx_byte
);
    localparam int CW = (P_BAUD_DIV > 4) ? $clog2(P_BAUD_DIV) : 2;
    localparam logic [CW-1:0] BIT_LAST  = CW'(P_BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(P_BAUD_DIV / 2 - 1);

    // ---------------- transmitter ----------------
    tx_state_e     tx_state_reg, tx_state_next;
    logic [CW-1:0] tx_cnt_reg;
    logic [2:0]    tx_bit_reg;
    logic [7:0]    tx_shift_reg;
    logic          tx_done_reg;
    logic          tx_bit_end;

    assign tx_bit_end = (tx_cnt_reg == BIT_LAST);

    always_comb begin
        tx_state_next = tx_state_reg;
        case (tx_state_reg)
            TX_IDLE:  if (tx_start) tx_state_next = TX_START;
            TX_START: if (tx_bit_end) tx_state_next = TX_DATA;
            TX_DATA:  if (tx_bit_end && tx_bit_reg == 3'd7) tx_state_next = TX_STOP;
            TX_STOP:  if (tx_bit_end) tx_state_next = TX_IDLE;
            default:  tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            tx_done_reg  <= 1'b0;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_done_reg  <= (tx_state_reg == TX_STOP) && tx_bit_end;
            if (tx_state_reg == TX_IDLE) begin
                tx_cnt_reg <= '0;
                tx_bit_reg <= '0;
                if (tx_start) tx_shift_reg <= tx_data;
            end else begin
                tx_cnt_reg <= tx_bit_end ? '0 : tx_cnt_reg + CW'(1);
                if (tx_state_reg == TX_DATA && tx_bit_end) begin
                    tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                    tx_bit_reg   <= tx_bit_reg + 3'd1;
                end
            end
        end
    end

    assign txd     = (tx_state_reg == TX_START) ? 1'b0 :
                     (tx_state_reg == TX_DATA)  ? tx_shift_reg[0] : 1'b1;
    assign tx_busy = (tx_state_reg != TX_IDLE);
    assign tx_done = tx_done_reg;

    // ---------------- receiver ----------------
    // START waits half a bit so every later sample lands mid-bit; a line that
    // returns high before then is treated as a glitch.
    rx_state_e     rx_state_reg, rx_state_next;
    logic [CW-1:0] rx_cnt_reg;
    logic [2:0]    rx_bit_reg;
    logic [7:0]    rx_shift_reg;
    logic [7:0]    rx_data_reg;
    logic          rx_valid_reg, rx_overrun_reg, rx_byte_reg;
    logic          rx_bit_end, rx_got;

    assign rx_bit_end = (rx_cnt_reg == BIT_LAST);

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_got        = 1'b0;
        case (rx_state_reg)
            RX_IDLE:  if (!rxd) rx_state_next = RX_START;
            RX_START: begin
                if (rxd) rx_state_next = RX_IDLE;
                else if (rx_cnt_reg == HALF_LAST) rx_state_next = RX_DATA;
            end
            RX_DATA:  if (rx_bit_end && rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
            RX_STOP:  if (rx_bit_end) begin
                rx_state_next = RX_IDLE;
                rx_got        = rxd;      // low stop bit: framing error, drop byte
            end
            default:  rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rx_state_reg   <= RX_IDLE;
            rx_cnt_reg     <= '0;
            rx_bit_reg     <= '0;
            rx_shift_reg   <= '0;
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            rx_overrun_reg <= 1'b0;
            rx_byte_reg    <= 1'b0;
        end else begin
            rx_state_reg <= rx_state_next;
            rx_byte_reg  <= rx_got;
            if (rx_state_reg == RX_IDLE || rx_state_next != rx_state_reg || rx_bit_end)
                rx_cnt_reg <= '0;
            else
                rx_cnt_reg <= rx_cnt_reg + CW'(1);
            if (rx_state_reg == RX_START) begin
                rx_bit_reg <= '0;
            end else if (rx_state_reg == RX_DATA && rx_bit_end) begin
                rx_shift_reg <= {rxd, rx_shift_reg[7:1]};
                rx_bit_reg   <= rx_bit_reg + 3'd1;
            end
            // A fresh byte always overwrites; overrun only if the old one was unread.
            if (rx_got) begin
                rx_data_reg    <= rx_shift_reg;
                rx_valid_reg   <= 1'b1;
                rx_overrun_reg <= (rx_valid_reg || rx_overrun_reg) && !rx_clear;
            end else if (rx_clear) begin
                rx_valid_reg   <= 1'b0;
                rx_overrun_reg <= 1'b0;
            end
        end
    end

    assign rx_data    = rx_data_reg;
    assign rx_valid   = rx_valid_reg;
    assign rx_overrun = rx_overrun_reg;
    assign rx_byte    = rx_byte_reg;

endmodule

// File: rtl/zcu102_base.sv
// AXI4-Lite slave for the ZCU102 base platform: LEDs, switches, buttons, UART,
// aux fabric reset and one level interrupt to the PS.
// Ports:
//  ACLK, ARESET           clock, synchronous active-high reset
//  s_aw*/s_w*/s_b*        AXI4-Lite write address/data/response channels
//  s_ar*/s_r*             AXI4-Lite read address/data channels
//  irq                    registered |(IRQ_STAT & IRQ_EN)
//  leds, switches, buttons board I/O (inputs are asynchronous)
//  uart_rxd, uart_txd     serial lines, idle high
//  aux_resetn             active-low fabric reset (ARESET or CTRL[0])
module zcu102_base
    import zcu102_base_pkg::*;
#(
    parameter int P_ADDR_WIDTH = 8,
    parameter int P_DATA_WIDTH = 32,
    parameter int P_NUM_LED    = 8,
    parameter int P_NUM_SWITCH = 8,
    parameter int P_NUM_BUTTON = 5,
    parameter int P_BAUD_DIV   = 868
)
(
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [P_ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [2:0]                s_awprot,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    input  logic [P_DATA_WIDTH-1:0]   s_wdata,
    input  logic [P_DATA_WIDTH/8-1:0] s_wstrb,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    output logic [1:0]                s_bresp,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    input  logic [P_ADDR_WIDTH-1:0]   s_araddr,
    input  logic [2:0]                s_arprot,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    output logic [P_DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      irq,
    output logic [P_NUM_LED-1:0]      leds,
    input  logic [P_NUM_SWITCH-1:0]   switches,
    input  logic [P_NUM_BUTTON-1:0]   buttons,
    input  logic                      uart_rxd,
    output logic                      uart_txd,
    output logic                      aux_resetn
);
    // ---------------- input synchronisers + edge history ----------------
    logic [P_NUM_SWITCH-1:0] sw_meta_reg, sw_sync_reg, sw_prev_reg;
    logic [P_NUM_BUTTON-1:0] btn_meta_reg, btn_sync_reg, btn_prev_reg;
    logic                    rxd_meta_reg, rxd_sync_reg;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            sw_meta_reg  <= '0;  sw_sync_reg  <= '0;  sw_prev_reg  <= '0;
            btn_meta_reg <= '0;  btn_sync_reg <= '0;  btn_prev_reg <= '0;
            rxd_meta_reg <= 1'b1; rxd_sync_reg <= 1'b1;   // line idles high
        end else begin
            sw_meta_reg  <= switches;     sw_sync_reg  <= sw_meta_reg;  sw_prev_reg  <= sw_sync_reg;
            btn_meta_reg <= buttons;      btn_sync_reg <= btn_meta_reg; btn_prev_reg <= btn_sync_reg;
            rxd_meta_reg <= uart_rxd;     rxd_sync_reg <= rxd_meta_reg;
        end
    end

    // ---------------- write channel ----------------
    // Address and data are parked independently; the write is applied once
    // both are parked, and the holders are released on the B handshake.
    wr_state_e   wr_state_reg, wr_state_next;
    logic        aw_held_reg, w_held_reg;
    logic [7:0]  aw_addr_reg;
    logic [31:0] w_data_reg;
    logic [3:0]  w_strb_reg;
    logic        wr_apply, wr_done;
    logic [7:0]  waddr;
    logic [31:0] wr_bytes;

    always_comb begin
        wr_state_next = wr_state_reg;
        wr_apply      = 1'b0;
        wr_done       = 1'b0;
        case (wr_state_reg)
            WR_COLLECT: if (aw_held_reg && w_held_reg) begin
                wr_apply      = 1'b1;
                wr_state_next = WR_RESP;
            end
            WR_RESP: if (s_bready) begin
                wr_done       = 1'b1;
                wr_state_next = WR_COLLECT;
            end
            default: wr_state_next = WR_COLLECT;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state_reg <= WR_COLLECT;
            aw_held_reg  <= 1'b0;
            w_held_reg   <= 1'b0;
            aw_addr_reg  <= '0;
            w_data_reg   <= '0;
            w_strb_reg   <= '0;
        end else begin
            wr_state_reg <= wr_state_next;
            if (wr_done) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
            end else begin
                if (s_awvalid && !aw_held_reg) begin
                    aw_held_reg <= 1'b1;
                    aw_addr_reg <= 8'(s_awaddr);
                end
                if (s_wvalid && !w_held_reg) begin
                    w_held_reg <= 1'b1;
                    w_data_reg <= 32'(s_wdata);
                    w_strb_reg <= 4'(s_wstrb);
                end
            end
        end
    end

    assign s_awready = ~aw_held_reg;
    assign s_wready  = ~w_held_reg;
    assign s_bvalid  = (wr_state_reg == WR_RESP);
    assign s_bresp   = RESP_OKAY;
    assign waddr     = aw_addr_reg & 8'hFC;
    assign wr_bytes  = apply_strb(32'd0, w_data_reg, w_strb_reg);   // strobed bytes only

    // ---------------- registers ----------------
    logic [P_NUM_LED-1:0] led_reg;
    logic [IRQ_W-1:0]     irq_stat_reg, irq_stat_next, irq_en_reg, irq_event, irq_clr;
    logic                 ctrl_reg, irq_reg;
    logic [31:0]          scratch_reg;
    logic                 tx_start, tx_busy, tx_done, rx_valid, rx_overrun, rx_byte, rx_clear;
    logic [7:0]           rx_data;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            led_reg     <= '0;
            irq_en_reg  <= '0;
            ctrl_reg    <= 1'b0;
            scratch_reg <= '0;
        end else if (wr_apply) begin
            case (waddr)
                ADDR_LED:     led_reg     <= P_NUM_LED'(apply_strb(32'(led_reg), w_data_reg, w_strb_reg));
                ADDR_IRQ_EN:  irq_en_reg  <= IRQ_W'(apply_strb(32'(irq_en_reg), w_data_reg, w_strb_reg));
                ADDR_CTRL:    ctrl_reg    <= w_strb_reg[0] ? w_data_reg[0] : ctrl_reg;
                ADDR_SCRATCH: scratch_reg <= apply_strb(scratch_reg, w_data_reg, w_strb_reg);
                default:      ;
            endcase
        end
    end

    assign tx_start = wr_apply && (waddr == ADDR_UART_TX) && w_strb_reg[0];

    // ---------------- interrupt status (W1C, set wins) ----------------
    always_comb begin
        irq_event = '0;
        irq_event[P_NUM_BUTTON-1:0] = btn_sync_reg & ~btn_prev_reg;
        irq_event[IRQ_SW] = |(sw_sync_reg ^ sw_prev_reg);
        irq_event[IRQ_RX] = rx_byte;
        irq_event[IRQ_TX] = tx_done;
    end

    assign irq_clr = (wr_apply && waddr == ADDR_IRQ_STAT) ? wr_bytes[IRQ_W-1:0] : '0;

    for (genvar gi = 0; gi < IRQ_W; gi++) begin : g_irq_stat
        assign irq_stat_next[gi] = irq_event[gi] | (irq_stat_reg[gi] & ~irq_clr[gi]);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            irq_stat_reg <= '0;
            irq_reg      <= 1'b0;
        end else begin
            irq_stat_reg <= irq_stat_next;
            irq_reg      <= |(irq_stat_reg & irq_en_reg);
        end
    end

    // ---------------- read channel ----------------
    logic        rvalid_reg, ar_fire;
    logic [31:0] rdata_reg, rd_mux;
    logic [7:0]  raddr;

    assign raddr    = 8'(s_araddr) & 8'hFC;
    assign ar_fire  = s_arvalid && !rvalid_reg;
    assign rx_clear = ar_fire && (raddr == ADDR_UART_RX);

    always_comb begin
        rd_mux = '0;
        case (raddr)
            ADDR_LED:       rd_mux = 32'(led_reg);
            ADDR_SWITCH:    rd_mux = 32'(sw_sync_reg);
            ADDR_BUTTON:    rd_mux = 32'(btn_sync_reg);
            ADDR_IRQ_STAT:  rd_mux = 32'(irq_stat_reg);
            ADDR_IRQ_EN:    rd_mux = 32'(irq_en_reg);
            ADDR_UART_RX:   rd_mux = {24'd0, rx_data};
            ADDR_UART_STAT: rd_mux = {29'd0, rx_overrun, rx_valid, tx_busy};
            ADDR_CTRL:      rd_mux = {31'd0, ctrl_reg};
            ADDR_SCRATCH:   rd_mux = scratch_reg;
            default:        rd_mux = '0;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
        end else if (ar_fire) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= rd_mux;
        end else if (s_rready) begin
            rvalid_reg <= 1'b0;
        end
    end

    assign s_arready = ~rvalid_reg;
    assign s_rvalid  = rvalid_reg;
    assign s_rdata   = P_DATA_WIDTH'(rdata_reg);
    assign s_rresp   = RESP_OKAY;

    // ---------------- UART + outputs ----------------
    zcu102_base_uart #(.P_BAUD_DIV(P_BAUD_DIV)) u_uart (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .tx_start   (tx_start),
        .tx_data    (w_data_reg[7:0]),
        .txd        (uart_txd),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .rxd        (rxd_sync_reg),
        .rx_clear   (rx_clear),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_overrun (rx_overrun),
        .rx_byte    (rx_byte)
    );

    assign irq        = irq_reg;
    assign leds       = led_reg;
    assign aux_resetn = ~(ARESET | ctrl_reg);

    // Protection bits and the byte-offset address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s_awprot, s_arprot, aw_addr_reg[1:0], raddr[1:0]};

endmodule

// File: tb/tb_zcu102_base.sv
// Directed bench for zcu102_base: reset state, split AW/W writes, strobes,
// unmapped accesses, switch/button interrupts with W1C, UART loopback and
// a stalled write response. UART runs at 16 clocks per bit to keep it short.
module tb_zcu102_base;
    localparam int BAUD = 16;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [7:0]  s_awaddr, s_araddr;
    logic [2:0]  s_awprot, s_arprot;
    logic [31:0] s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp, s_rresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic        irq, uart_rxd, uart_txd, aux_resetn;
    logic [7:0]  leds, switches;
    logic [4:0]  buttons;

    int vectors     = 0;
    int miscompares = 0;

    always #5 ACLK = ~ACLK;
    assign uart_rxd = uart_txd;   // loopback

    zcu102_base #(.P_BAUD_DIV(BAUD)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .irq(irq), .leds(leds), .switches(switches), .buttons(buttons),
        .uart_rxd(uart_rxd), .uart_txd(uart_txd), .aux_resetn(aux_resetn)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                             input logic [3:0] s, input bit hold_b);
        int  n;
        logic aw_f, w_f;
        @(negedge ACLK);
        s_awvalid = 1'b1; s_awaddr = a; s_wvalid = 1'b1; s_wdata = d; s_wstrb = s;
        s_bready  = !hold_b;
        n = 0;
        while ((s_awvalid || s_wvalid) && n < 50) begin
            aw_f = s_awvalid && s_awready;
            w_f  = s_wvalid && s_wready;
            @(negedge ACLK);
            n++;
            if (aw_f) s_awvalid = 1'b0;
            if (w_f)  s_wvalid  = 1'b0;
        end
        chk("wr_accept_pending", {31'd0, s_awvalid | s_wvalid}, 32'd0);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        n = 0;
        while (!s_bvalid && n < 50) begin @(negedge ACLK); n++; end
        chk("bvalid_seen", {31'd0, s_bvalid}, 32'd1);
        chk("bresp", {30'd0, s_bresp}, 32'd0);
        if (hold_b) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge ACLK);
                chk("bvalid_stall", {31'd0, s_bvalid}, 32'd1);
                chk("awready_stall", {31'd0, s_awready}, 32'd0);
            end
            s_bready = 1'b1;
        end
        @(negedge ACLK);
        chk("bvalid_after_b", {31'd0, s_bvalid}, 32'd0);
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d);
        int n;
        @(negedge ACLK);
        s_arvalid = 1'b1; s_araddr = a;
        n = 0;
        while (!s_arready && n < 50) begin @(negedge ACLK); n++; end
        @(negedge ACLK);
        s_arvalid = 1'b0;
        n = 0;
        while (!s_rvalid && n < 50) begin @(negedge ACLK); n++; end
        chk("rvalid_seen", {31'd0, s_rvalid}, 32'd1);
        d = s_rdata;
        @(negedge ACLK);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(a, d);
        chk(tag, d, exp);
    endtask

    initial begin
        logic [31:0] d;
        logic [9:0]  frame_exp;
        int          n;

        ARESET = 1'b1;
        s_awvalid = 0; s_awaddr = 0; s_awprot = 0; s_wvalid = 0; s_wdata = 0; s_wstrb = 0;
        s_bready = 1; s_arvalid = 0; s_araddr = 0; s_arprot = 0; s_rready = 1;
        switches = 8'h00; buttons = 5'h00;

        // ---- reset ----
        repeat (5) @(negedge ACLK);
        chk("rst_awready", {31'd0, s_awready}, 32'd1);
        chk("rst_wready", {31'd0, s_wready}, 32'd1);
        chk("rst_arready", {31'd0, s_arready}, 32'd1);
        chk("rst_bvalid", {31'd0, s_bvalid}, 32'd0);
        chk("rst_rvalid", {31'd0, s_rvalid}, 32'd0);
        chk("rst_rdata", s_rdata, 32'd0);
        chk("rst_leds", {24'd0, leds}, 32'd0);
        chk("rst_txd", {31'd0, uart_txd}, 32'd1);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_aux_resetn", {31'd0, aux_resetn}, 32'd0);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("aux_resetn_released", {31'd0, aux_resetn}, 32'd1);

        // ---- AW alone, W three cycles later ----
        s_awvalid = 1'b1; s_awaddr = 8'hFF;
        @(negedge ACLK);
        s_awvalid = 1'b0;
        chk("awready_after_aw", {31'd0, s_awready}, 32'd0);
        repeat (2) @(negedge ACLK);
        chk("bvalid_aw_only", {31'd0, s_bvalid}, 32'd0);
        s_wvalid = 1'b1; s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF;
        @(negedge ACLK);
        s_wvalid = 1'b0;
        chk("wready_after_w", {31'd0, s_wready}, 32'd0);
        @(negedge ACLK);
        chk("bvalid_both_held", {31'd0, s_bvalid}, 32'd1);
        @(negedge ACLK);
        chk("bvalid_split_done", {31'd0, s_bvalid}, 32'd0);
        chk("awready_back", {31'd0, s_awready}, 32'd1);
        rd_chk("scratch_rd", 8'hFC, 32'hDEADBEEF);
        axi_write(8'hFC, 32'h11223344, 4'b0100, 1'b0);
        rd_chk("scratch_strb", 8'hFC, 32'hDE22BEEF);

        // ---- LED, strobe, unmapped ----
        axi_write(8'h00, 32'h123456A5, 4'b0001, 1'b0);
        chk("leds_a5", {24'd0, leds}, 32'h000000A5);
        rd_chk("led_rd", 8'h00, 32'h000000A5);
        axi_write(8'h40, 32'hFFFFFFFF, 4'hF, 1'b0);
        chk("leds_unmapped_wr", {24'd0, leds}, 32'h000000A5);
        rd_chk("led_after_unmapped", 8'h00, 32'h000000A5);
        rd_chk("scratch_after_unmapped", 8'hFC, 32'hDE22BEEF);
        rd_chk("unmapped_rd", 8'h40, 32'd0);

        // ---- switches ----
        switches = 8'h3C;
        repeat (5) @(negedge ACLK);
        rd_chk("switch_rd", 8'h04, 32'h0000003C);
        rd_chk("irq_stat_sw", 8'h0C, 32'h00000100);
        axi_write(8'h0C, 32'h00000100, 4'hF, 1'b0);
        rd_chk("irq_stat_sw_clr", 8'h0C, 32'd0);

        // ---- button interrupt ----
        axi_write(8'h10, 32'h0000001F, 4'hF, 1'b0);
        rd_chk("irq_en_rd", 8'h10, 32'h0000001F);
        buttons[2] = 1'b1;
        repeat (4) @(negedge ACLK);
        buttons[2] = 1'b0;
        repeat (3) @(negedge ACLK);
        chk("irq_button", {31'd0, irq}, 32'd1);
        rd_chk("irq_stat_btn", 8'h0C, 32'h00000004);
        axi_write(8'h0C, 32'h00000004, 4'hF, 1'b0);
        repeat (2) @(negedge ACLK);
        chk("irq_cleared", {31'd0, irq}, 32'd0);
        rd_chk("irq_stat_btn_clr", 8'h0C, 32'd0);

        // ---- UART frame + loopback ----
        frame_exp = {1'b1, 8'h55, 1'b0};   // stop, data LSB first, start (bit 0 sent first)
        fork
            axi_write(8'h14, 32'h00000055, 4'hF, 1'b0);
            begin
                n = 0;
                while (uart_txd && n < 200) begin @(negedge ACLK); n++; end
                chk("tx_start_seen", {31'd0, uart_txd}, 32'd0);
                repeat (BAUD / 2) @(negedge ACLK);
                for (int b = 0; b < 10; b++) begin
                    chk($sformatf("tx_bit%0d", b), {31'd0, uart_txd}, {31'd0, frame_exp[b]});
                    repeat (BAUD) @(negedge ACLK);
                end
            end
        join
        n = 0;
        d = 32'd0;
        while (d[1] !== 1'b1 && n < 20) begin axi_read(8'h1C, d); n++; end
        chk("rx_valid_set", {31'd0, d[1]}, 32'd1);
        rd_chk("uart_rx_byte", 8'h18, 32'h00000055);
        repeat (20) @(negedge ACLK);
        rd_chk("uart_stat_idle", 8'h1C, 32'd0);
        rd_chk("irq_stat_uart", 8'h0C, 32'h00000600);
        chk("irq_uart_masked", {31'd0, irq}, 32'd0);

        // ---- stalled write response ----
        axi_write(8'hFC, 32'hCAFEF00D, 4'hF, 1'b1);
        rd_chk("scratch_stalled", 8'hFC, 32'hCAFEF00D);

        // ---- aux reset control ----
        axi_write(8'h20, 32'h00000001, 4'hF, 1'b0);
        chk("aux_resetn_ctrl", {31'd0, aux_resetn}, 32'd0);
        rd_chk("ctrl_rd", 8'h20, 32'h00000001);
        axi_write(8'h20, 32'h00000000, 4'hF, 1'b0);
        chk("aux_resetn_ctrl_off", {31'd0, aux_resetn}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
